// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO-fed UART transmitter with a byte FIFO and polling status.
// Frames are 8N1, LSB first; define UART_TX_PARITY_EN for 8E1 frames.
// tx is registered from the FSM output decode, so the line trails the state by one clock.
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 200,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               busy,
    output logic [FIFO_AW:0]   level,
    output logic               overflow,
    output logic               tx
);

    localparam int unsigned DEPTH  = 2 ** FIFO_AW;
    localparam int unsigned LVL_W  = FIFO_AW + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [LVL_W-1:0]     count_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 empty_c;
    logic                 full_now_c;
    logic                 baud_tc_c;
    logic                 pop_c;
    logic                 push_c;
    logic                 tx_c;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign empty_c    = (level == '0);
    assign full_now_c = (level == LVL_W'(DEPTH));
    assign baud_tc_c  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    // A simultaneous pop frees a slot, so a push is accepted even when full
    assign push_c     = wr_en && (!full_now_c || pop_c);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty_c) state_next = START;
            end
            START: begin
                if (baud_tc_c) state_next = DATA;
            end
            DATA: begin
                if (baud_tc_c && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tc_c) state_next = STOP;
            end
`endif
            STOP: begin
                if (baud_tc_c) state_next = empty_c ? IDLE : START;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: line level and FIFO pop request
    always_comb begin
        tx_c  = 1'b1;
        pop_c = 1'b0;
        case (state)
            IDLE: begin
                pop_c = !empty_c;
            end
            START: begin
                tx_c = 1'b0;
            end
            DATA: begin
                tx_c = shift[0];
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_c = par;
            end
`endif
            STOP: begin
                pop_c = baud_tc_c && !empty_c;
            end
            default: begin
                tx_c  = 1'b1;
                pop_c = 1'b0;
            end
        endcase
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = level;
        case ({push_c, pop_c})
            2'b10:   count_next = level + LVL_W'(1);
            2'b01:   count_next = level - LVL_W'(1);
            default: count_next = level;
        endcase
    end

    // FIFO storage (no reset needed; validity tracked by pointers)
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, status, baud/bit counters, shifter and line register
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            if (push_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            level <= count_next;
            full  <= (count_next == LVL_W'(DEPTH));
            busy  <= (state_next != IDLE) || (count_next != '0);
            if (wr_en && !push_c) overflow <= 1'b1;
            tx <= tx_c;

            if ((state == IDLE) || baud_tc_c) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            if (pop_c) begin
                shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                par   <= ^mem[rd_ptr];
`endif
            end else if ((state == DATA) && baud_tc_c) begin
                shift <= {1'b0, shift[7:1]};
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if ((state == DATA) && baud_tc_c) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule
